approx_mul_err_sweeper: RTL and testbench
=========================================

// Module: approx_mul_err_sweeper
// PURPOSE
//  Sequential error-characterisation engine for the 8x8 approximate multipliers.
//  On start, drives every operand pair (a,b) in 0..2^W-1 into an attached
//  multiplier and reads back its product. Compares each result with an internal
//  exact a*b and accumulates error statistics: error count, max and sum of
//  error distance, worst-case operands. Sits beside the multiplier under
//  test on the FPGA evaluation top; results are read after done.
// PARAMETERS
//  W        8  operand width; the sweep covers 2^(2W) pairs
//  DUT_LAT  0  multiplier latency in clocks, 0 = combinational; legal range 0..4
// PORTS
//  clk         in   1     rising-edge clock
//  rst_n       in   1     asynchronous active-low reset
//  start       in   1     1-cycle request to begin a sweep; honoured only in IDLE
//  abort       in   1     stop the sweep; statistics are kept, no done pulse
//  dut_a       out  W     operand A to the multiplier, registered
//  dut_b       out  W     operand B to the multiplier, registered
//  dut_prod    in   2W    multiplier product for the operands issued DUT_LAT clocks earlier
//  busy        out  1     high in SWEEP and DRAIN
//  done        out  1     1-cycle pulse when a sweep completes
//  err_count   out  2W+1  number of pairs with dut_prod != a*b
//  max_ed      out  2W    largest |a*b - dut_prod|
//  sum_ed      out  4W    sum of |a*b - dut_prod| over all pairs
//  worst_a     out  W     operand A of the first pair that reached max_ed
//  worst_b     out  W     operand B of the first pair that reached max_ed
// BEHAVIOUR
//  Reset: all outputs 0; FSM goes to IDLE; operand counter and delay line cleared.
//  FSM states: IDLE, SWEEP, DRAIN, FIN.
//  IDLE -> SWEEP on start:
//   - all statistics cleared to 0.
//   - operand counter cnt (2W bits) set to 0.
//  SWEEP, each clock:
//   - {dut_a,dut_b} <= cnt, then cnt++.
//   - issue is {dut_a,dut_b} registered from cnt, so the first pair (0,0) is on
//     the outputs one clock after start.
//   - when cnt wraps from all-ones to 0, the last pair has been issued -> DRAIN.
//  Delay line:
//   - a valid bit and the operands issued travel DUT_LAT stages.
//   - dut_prod is sampled on each clock where the aligned valid bit is high.
//   - DUT_LAT=0 samples in the same cycle the operands are driven.
//  Per sample:
//   - exact = a*b (2W bits, unsigned); ed = |exact - dut_prod| (2W bits).
//   - ed != 0 -> err_count++.
//   - sum_ed += ed (no overflow possible at 4W).
//   - ed > max_ed (strict) -> update max_ed, worst_a, worst_b; ties keep first.
//  DRAIN -> FIN when no valid entries remain in the delay line
//   (DUT_LAT clocks; zero-length drain when DUT_LAT=0).
//  FIN: done=1 for exactly one clock, then IDLE. Statistics hold until next start.
//  Every pair is sampled exactly once: 2^(2W) samples per sweep.
//  start while busy: ignored.
//  start in the same cycle as done: ignored (FIN is not IDLE).
//  abort in SWEEP or DRAIN:
//   - next state IDLE; delay line flushed.
//   - partial statistics held; no done pulse.
//   - abort takes priority over a same-cycle sample: that sample is discarded.
//  abort in IDLE or FIN: no effect.
//  rst_n low at any time, including mid-sweep: immediate clear to the reset state.
//  dut_a/dut_b hold their last value outside SWEEP.
// TESTING
//  1. Exact stub multiplier, DUT_LAT=0, pulse start:
//     -> done exactly 65537 clocks after start; err_count=0, max_ed=0, sum_ed=0.
//  2. Stub returning a*b ^ 16'h0001:
//     -> err_count=65536, max_ed=1, sum_ed=65536, worst=(0,0).
//  3. Stub exact except (a=3,b=5) returns 0:
//     -> err_count=1, max_ed=15, sum_ed=15, worst_a=3, worst_b=5.
//  4. DUT_LAT=2 with a 2-stage registered exact multiplier:
//     -> err_count=0; done 2 clocks later than in test 1.
//  5. Abort at clock 1000:
//     -> busy low next clock, no done; stats frozen.
//     Then start -> stats cleared and a full sweep repeats test-1 results.
//  6. rst_n low mid-sweep:
//     -> all outputs 0 asynchronously.
//     start pulsed while busy -> ignored, sweep length unchanged.

Source files
------------

// File: rtl/approx_mul_err_sweeper.sv
// Error-characterisation engine for an attached approximate multiplier.
// Walks every operand pair, compares the returned product against an exact
// reference and accumulates error count, max/sum of error distance and the
// first operands that produced the maximum.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start; statistics hold their last values
// S_SWEEP | issuing one operand pair per clock from the pair counter
// S_DRAIN | all pairs issued; waiting for the delay line to empty
// S_FIN   | one-clock done pulse, then back to S_IDLE
module approx_mul_err_sweeper #(
    parameter int W       = 8,
    parameter int DUT_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [W-1:0]     dut_a,
    output logic [W-1:0]     dut_b,
    input  logic [2*W-1:0]   dut_prod,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [2*W-1:0]   max_ed,
    output logic [4*W-1:0]   sum_ed,
    output logic [W-1:0]     worst_a,
    output logic [W-1:0]     worst_b
);

    localparam int PW = 2 * W;
    localparam int EW = 2 * W + 1;
    localparam int SW = 4 * W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [PW-1:0]  cnt;
    logic           last_pair;

    // vld_line[0] / op_line[0] are the issue registers; stage DUT_LAT is the
    // one aligned with dut_prod.
    logic [DUT_LAT:0] vld_line;
    logic [PW-1:0]    op_line [0:DUT_LAT];

    logic           issue;
    logic           clear_stats;
    logic           flush;
    logic           upstream_busy;
    logic           sample;

    logic [W-1:0]   samp_a;
    logic [W-1:0]   samp_b;
    logic [PW-1:0]  exact;
    logic [PW-1:0]  ed;

    assign last_pair = (cnt == {PW{1'b1}});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort wins over normal progress while busy.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_SWEEP;
                end
            end
            S_SWEEP: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (last_pair) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (!upstream_busy) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs and datapath enables.
    always_comb begin
        busy        = (state == S_SWEEP) || (state == S_DRAIN);
        done        = (state == S_FIN);
        issue       = (state == S_SWEEP) && !abort;
        clear_stats = (state == S_IDLE) && start;
        flush       = busy && abort;
    end

    // Entries still travelling towards the sample stage. The last stage is
    // excluded: it is consumed on the same edge that leaves S_DRAIN.
    always_comb begin
        upstream_busy = 1'b0;
        for (int i = 0; i < DUT_LAT; i++) begin
            upstream_busy = upstream_busy | vld_line[i];
        end
    end

    // Operand pair counter: restarts on start, advances once per issued pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear_stats) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= cnt + PW'(1);
        end
    end

    // Issue registers plus delay line; stage 0 holds its value when not issuing
    // so the multiplier inputs stay put outside the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_line <= '0;
            for (int i = 0; i <= DUT_LAT; i++) begin
                op_line[i] <= '0;
            end
        end else begin
            if (flush) begin
                vld_line <= '0;
            end else begin
                vld_line[0] <= issue;
                for (int i = 1; i <= DUT_LAT; i++) begin
                    vld_line[i] <= vld_line[i-1];
                end
            end
            if (issue) begin
                op_line[0] <= cnt;
            end
            for (int i = 1; i <= DUT_LAT; i++) begin
                op_line[i] <= op_line[i-1];
            end
        end
    end

    assign dut_a = op_line[0][PW-1:W];
    assign dut_b = op_line[0][W-1:0];

    // Exact reference and absolute error distance for the aligned pair.
    always_comb begin
        samp_a = op_line[DUT_LAT][PW-1:W];
        samp_b = op_line[DUT_LAT][W-1:0];
        exact  = PW'(samp_a) * PW'(samp_b);
        if (dut_prod > exact) begin
            ed = dut_prod - exact;
        end else begin
            ed = exact - dut_prod;
        end
        sample = vld_line[DUT_LAT] && !flush;
    end

    // Statistics accumulation; cleared on start, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (clear_stats) begin
            err_count <= '0;
            max_ed    <= '0;
            sum_ed    <= '0;
            worst_a   <= '0;
            worst_b   <= '0;
        end else if (sample) begin
            if (ed != '0) begin
                err_count <= err_count + EW'(1);
            end
            sum_ed <= sum_ed + SW'(ed);
            if (ed > max_ed) begin
                max_ed  <= ed;
                worst_a <= samp_a;
                worst_b <= samp_b;
            end
        end
    end

endmodule

// File: tb/tb_approx_mul_err_sweeper.sv
module tb_approx_mul_err_sweeper;

    typedef struct {
        longint      done_cyc;
        logic [16:0] err;
        logic [15:0] mx;
        logic [31:0] sm;
        logic [7:0]  wa;
        logic [7:0]  wb;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   rst4_n;
    logic   start_m;
    logic   abort_m;
    logic   start4;
    logic   abort4;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;

    exp_t q [5][$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare_res(input int id, input exp_t e, input longint c,
                               input logic [16:0] ec, input logic [15:0] mx,
                               input logic [31:0] sm, input logic [7:0] wa,
                               input logic [7:0] wb);
        chk($sformatf("inst%0d_done_cycle", id), 64'(c), 64'(e.done_cyc));
        chk($sformatf("inst%0d_err_count", id), 64'(ec), 64'(e.err));
        chk($sformatf("inst%0d_max_ed", id), 64'(mx), 64'(e.mx));
        chk($sformatf("inst%0d_sum_ed", id), 64'(sm), 64'(e.sm));
        chk($sformatf("inst%0d_worst_a", id), 64'(wa), 64'(e.wa));
        chk($sformatf("inst%0d_worst_b", id), 64'(wb), 64'(e.wb));
    endtask

    task automatic wait_drain(input int id, input int limit);
        int n = 0;
        while (q[id].size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (q[id].size() != 0) begin
            checks++;
            errors++;
            $display("FAIL inst%0d_done_timeout waited %0d cycles, %0d results outstanding", id, n, q[id].size());
            q[id].delete();
        end
    endtask

    function automatic exp_t mk(input longint dc, input int ec, input int mx, input int sm,
                                input int wa, input int wb);
        exp_t e;
        e.done_cyc = dc;
        e.err      = 17'(ec);
        e.mx       = 16'(mx);
        e.sm       = 32'(sm);
        e.wa       = 8'(wa);
        e.wb       = 8'(wb);
        return e;
    endfunction

    // 8-bit instances: 0 exact, 1 lsb flipped, 2 single bad pair, 3 two-stage pipe
    for (genvar g = 0; g < 4; g++) begin : gen_w8
        logic [7:0]  dut_a;
        logic [7:0]  dut_b;
        logic [15:0] dut_prod;
        logic [15:0] exact_p;
        logic [15:0] p1;
        logic [15:0] p2;
        logic        busy;
        logic        done;
        logic [16:0] err_count;
        logic [15:0] max_ed;
        logic [31:0] sum_ed;
        logic [7:0]  worst_a;
        logic [7:0]  worst_b;
        exp_t        e;

        always @(posedge clk) begin
            p1 <= exact_p;
            p2 <= p1;
        end

        always_comb begin
            exact_p  = 16'(dut_a) * 16'(dut_b);
            dut_prod = exact_p;
            if (g == 1) dut_prod = exact_p ^ 16'h0001;
            else if (g == 2 && dut_a == 8'd3 && dut_b == 8'd5) dut_prod = '0;
            else if (g == 3) dut_prod = p2;
        end

        approx_mul_err_sweeper #(.W(8), .DUT_LAT((g == 3) ? 2 : 0)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start_m),
            .abort     (abort_m),
            .dut_a     (dut_a),
            .dut_b     (dut_b),
            .dut_prod  (dut_prod),
            .busy      (busy),
            .done      (done),
            .err_count (err_count),
            .max_ed    (max_ed),
            .sum_ed    (sum_ed),
            .worst_a   (worst_a),
            .worst_b   (worst_b)
        );

        always @(negedge clk) begin
            if (done) begin
                if (q[g].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL inst%0d_unexpected_done at cycle %0d", g, cyc);
                end else begin
                    e = q[g].pop_front();
                    compare_res(g, e, cyc, err_count, max_ed, sum_ed, worst_a, worst_b);
                end
            end
        end
    end

    // 4-bit instance for abort/reset tests: product forced to 0 when a == b
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  prod4;
    logic        busy4;
    logic        done4;
    logic [8:0]  err4;
    logic [7:0]  max4;
    logic [15:0] sum4;
    logic [3:0]  wa4;
    logic [3:0]  wb4;
    exp_t        e4;

    always_comb prod4 = (a4 == b4) ? 8'd0 : 8'(a4) * 8'(b4);

    approx_mul_err_sweeper #(.W(4), .DUT_LAT(0)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst4_n),
        .start     (start4),
        .abort     (abort4),
        .dut_a     (a4),
        .dut_b     (b4),
        .dut_prod  (prod4),
        .busy      (busy4),
        .done      (done4),
        .err_count (err4),
        .max_ed    (max4),
        .sum_ed    (sum4),
        .worst_a   (wa4),
        .worst_b   (wb4)
    );

    always @(negedge clk) begin
        if (done4) begin
            if (q[4].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL inst4_unexpected_done at cycle %0d", cyc);
            end else begin
                e4 = q[4].pop_front();
                compare_res(4, e4, cyc, {8'b0, err4}, {8'b0, max4}, {16'b0, sum4},
                            {4'b0, wa4}, {4'b0, wb4});
            end
        end
    end

    initial begin
        int n;
        rst_n   = 1'b0;
        rst4_n  = 1'b0;
        start_m = 1'b0;
        abort_m = 1'b0;
        start4  = 1'b0;
        abort4  = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst0_busy_done", 64'({gen_w8[0].busy, gen_w8[0].done}), 64'd0);
        chk("rst0_operands", 64'({gen_w8[0].dut_a, gen_w8[0].dut_b}), 64'd0);
        chk("rst0_err_max", 64'({gen_w8[0].err_count, gen_w8[0].max_ed}), 64'd0);
        chk("rst0_sum", 64'(gen_w8[0].sum_ed), 64'd0);
        chk("rst0_worst", 64'({gen_w8[0].worst_a, gen_w8[0].worst_b}), 64'd0);
        chk("rst4_all", 64'({busy4, done4, a4, b4, err4, max4, sum4, wa4, wb4}), 64'd0);

        @(negedge clk);
        rst_n  = 1'b1;
        rst4_n = 1'b1;
        @(negedge clk);

        // abort: pair (6,6) would be sampled on the abort edge and must be dropped
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        chk("abort_busy_after_start", 64'(busy4), 64'd1);
        repeat (103) @(posedge clk);
        @(negedge clk);
        abort4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort4 = 1'b0;
        chk("abort_busy_low", 64'(busy4), 64'd0);
        chk("abort_err", 64'(err4), 64'd5);
        chk("abort_sum", 64'(sum4), 64'd55);
        chk("abort_max", 64'(max4), 64'd25);
        chk("abort_worst", 64'({wa4, wb4}), 64'h55);
        repeat (20) @(negedge clk);
        chk("abort_frozen_err_sum", 64'({err4, sum4}), 64'({9'd5, 16'd55}));
        chk("abort_idle_busy", 64'(busy4), 64'd0);

        // restart after abort: stats cleared, then a full sweep
        start4 = 1'b1;
        q[4].push_back(mk(cyc + 1 + 257, 15, 225, 1240, 15, 15));
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        chk("restart_cleared", 64'({err4, sum4, max4}), 64'd0);
        wait_drain(4, 400);

        // asynchronous reset mid-sweep
        @(negedge clk);
        start4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (50) @(posedge clk);
        #3 rst4_n = 1'b0;
        #1;
        chk("midreset_busy", 64'(busy4), 64'd0);
        chk("midreset_stats", 64'({err4, max4, sum4, wa4, wb4}), 64'd0);
        chk("midreset_operands", 64'({a4, b4}), 64'd0);
        @(negedge clk);
        rst4_n = 1'b1;
        @(negedge clk);

        // start while busy and start on the done cycle are both ignored
        start4 = 1'b1;
        q[4].push_back(mk(cyc + 1 + 257, 15, 225, 1240, 15, 15));
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        repeat (10) @(negedge clk);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("ignored_start_done_seen", 64'(done4), 64'd1);
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        chk("start_on_done_ignored", 64'(busy4), 64'd0);
        repeat (3) @(negedge clk);
        chk("start_on_done_still_idle", 64'(busy4), 64'd0);
        wait_drain(4, 10);

        // full 8-bit sweeps on all four stubs in parallel
        start_m = 1'b1;
        q[0].push_back(mk(cyc + 1 + 65537, 0, 0, 0, 0, 0));
        q[1].push_back(mk(cyc + 1 + 65537, 65536, 1, 65536, 0, 0));
        q[2].push_back(mk(cyc + 1 + 65537, 1, 15, 15, 3, 5));
        q[3].push_back(mk(cyc + 1 + 65539, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        start_m = 1'b0;
        chk("sweep_busy", 64'(gen_w8[0].busy), 64'd1);
        repeat (300) @(negedge clk);
        chk("sweep_operands_pair299", 64'({gen_w8[0].dut_a, gen_w8[0].dut_b}), 64'h012B);
        wait_drain(0, 66000);
        wait_drain(1, 100);
        wait_drain(2, 100);
        wait_drain(3, 100);
        repeat (2) @(negedge clk);
        chk("hold_operands_after_sweep", 64'({gen_w8[0].dut_a, gen_w8[0].dut_b}), 64'hFFFF);
        chk("idle_after_sweep", 64'({gen_w8[0].busy, gen_w8[3].busy}), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
